// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector: samples OVL checker fire bits, timestamps each firing
// cycle into a small event FIFO drained over valid/ready, and keeps sticky
// status, first-fire time and a saturating drop count.
// Optional feature macro: OVL_FIRE_COLLECTOR_CNT_EN builds per-checker fire
// counters; when undefined cnt_out is tied to 0 and cnt_sel is ignored.
module ovl_fire_collector #(
  parameter int unsigned NUM_CHK = 4,
  parameter int unsigned TS_W    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [NUM_CHK-1:0] fire_in,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [NUM_CHK-1:0] evt_fire,
  output logic [TS_W-1:0]    evt_ts,
  output logic [1:0]         status,
  output logic [TS_W-1:0]    first_ts,
  output logic [7:0]         drop_cnt,
  input  logic [3:0]         cnt_sel,
  output logic [CNT_W-1:0]   cnt_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StFired    = 2'b01,
    StOverflow = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q;
  logic [TS_W-1:0]   first_ts_q;
  logic [7:0]        drop_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic [NUM_CHK-1:0] fire_mem [DEPTH];
  logic [TS_W-1:0]   ts_mem [DEPTH];

  logic evt, full, pop, push, drop;

  assign evt       = enable & (|fire_in);
  assign full      = (count_q == FullCnt);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push      = evt & (~full | pop);
  assign drop      = evt & full & ~pop;

  // Head outputs are gated so an empty FIFO always presents zeros.
  assign evt_fire = evt_valid ? fire_mem[rd_ptr_q] : '0;
  assign evt_ts   = evt_valid ? ts_mem[rd_ptr_q] : '0;
  assign status   = state_q;
  assign first_ts = first_ts_q;
  assign drop_cnt = drop_q;

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Event storage; contents are only visible through the gated head outputs.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      fire_mem[wr_ptr_q] <= fire_in;
      ts_mem[wr_ptr_q]   <= ts_q;
    end
  end

  // Timestamp, first-fire capture and saturating drop counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      first_ts_q <= '0;
      drop_q     <= '0;
    end else if (clear) begin
      ts_q       <= '0;
      first_ts_q <= '0;
      drop_q     <= '0;
    end else begin
      if (enable) ts_q <= ts_q + 1'b1;
      // Captured even when that first event is itself dropped.
      if (evt && state_q == StIdle) first_ts_q <= ts_q;
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  // Status state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Status next state; OVERFLOW is left only by clear or reset.
  always_comb begin
    state_d = state_q;
    if (clear)                         state_d = StIdle;
    else if (drop)                     state_d = StOverflow;
    else if (evt && state_q == StIdle) state_d = StFired;
  end

`ifdef OVL_FIRE_COLLECTOR_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_CHK];

  // Per-checker saturating fire counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CHK; i++) cnt_q[i] <= '0;
    end else if (evt) begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (fire_in[i] && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  // Counter read mux; out-of-range selects read as zero.
  always_comb begin
    cnt_out = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (cnt_sel == i[3:0]) cnt_out = cnt_q[i];
    end
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_out        = '0;
`endif

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed, table-driven bench for ovl_fire_collector (default parameters).
module tb_ovl_fire_collector;

`ifdef OVL_FIRE_COLLECTOR_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clock, reset, enable, clear, evt_ready, evt_valid;
  logic [3:0]  fire_in, evt_fire, cnt_sel;
  logic [31:0] evt_ts, first_ts;
  logic [1:0]  status;
  logic [7:0]  drop_cnt;
  logic [15:0] cnt_out;

  int total = 0;
  int bad   = 0;

  ovl_fire_collector #(.NUM_CHK(4), .TS_W(32), .DEPTH(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .fire_in(fire_in),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_fire(evt_fire), .evt_ts(evt_ts),
    .status(status), .first_ts(first_ts), .drop_cnt(drop_cnt), .cnt_sel(cnt_sel),
    .cnt_out(cnt_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        en;
    logic        clr;
    logic [3:0]  fire;
    logic        rdy;
    logic [3:0]  sel;
    logic        valid;
    logic [3:0]  efire;
    logic [31:0] ets;
    logic [1:0]  st;
    logic [31:0] first;
    logic [7:0]  drop;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic en, input logic clr, input logic [3:0] f,
                       input logic rdy, input logic [3:0] sel);
    enable = en; clear = clr; fire_in = f; evt_ready = rdy; cnt_sel = sel;
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    chk({tag, ".valid"},  64'(evt_valid), 64'(v.valid));
    chk({tag, ".fire"},   64'(evt_fire),  64'(v.efire));
    chk({tag, ".ts"},     64'(evt_ts),    64'(v.ets));
    chk({tag, ".status"}, 64'(status),    64'(v.st));
    chk({tag, ".first"},  64'(first_ts),  64'(v.first));
    chk({tag, ".drop"},   64'(drop_cnt),  64'(v.drop));
    chk({tag, ".cnt"},    64'(cnt_out),   CntEn ? 64'(v.cnt) : 64'd0);
  endtask

  initial begin
    logic [31:0] drain_ts [8];
    vec_t zero;

    // en clr fire rdy sel | valid efire ets st first drop cnt
    for (int i = 0; i < 5; i++)
      vecs[i] = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 32'd0, 2'b00, 32'd0, 8'd0, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 4'h1, 32'd5, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[6]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 4'h1, 32'd5, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[7]  = '{1'b1, 1'b0, 4'h8, 1'b1, 4'h3, 1'b1, 4'h8, 32'd7, 2'b01, 32'd5, 8'd0, 16'd1};
    for (int i = 8; i < 13; i++)
      vecs[i] = '{1'b0, 1'b0, 4'hF, 1'b0, 4'h3, 1'b1, 4'h8, 32'd7, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[13] = '{1'b1, 1'b0, 4'h4, 1'b1, 4'h2, 1'b1, 4'h4, 32'd8, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[14] = '{1'b1, 1'b0, 4'h0, 1'b1, 4'h3, 1'b0, 4'h0, 32'd0, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[15] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 4'h0, 32'd0, 2'b01, 32'd5, 8'd0, 16'd1};
    vecs[16] = '{1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 1'b0, 4'h0, 32'd0, 2'b00, 32'd0, 8'd0, 16'd0};
    zero     = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 32'd0, 2'b00, 32'd0, 8'd0, 16'd0};

    // Reset state.
    reset = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
    #12;
    chk_all("reset", zero);
    reset = 1'b1;
    step();

    // Ten quiet clocks after reset release.
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) step();
    chk_all("quiet", zero);

    // Clear restarts the timestamp at 0 for the table.
    drive(1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
    step();
    chk_all("clear0", zero);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].en, vecs[i].clr, vecs[i].fire, vecs[i].rdy, vecs[i].sel);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Overflow: ten events with the consumer stalled, events at ts 0..9.
    drive(1'b1, 1'b0, 4'h3, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) step();
    chk_all("ovf", '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0,
                     1'b1, 4'h3, 32'd0, 2'b11, 32'd0, 8'd2, 16'd10});

    // Full FIFO with a pop and a push (ts 10) in the same cycle.
    drive(1'b1, 1'b0, 4'h3, 1'b1, 4'h0);
    step();
    chk("popush.drop", 64'(drop_cnt), 64'd2);
    chk("popush.head", 64'(evt_ts), 64'd1);

    // Drain: exactly eight entries remain.
    for (int i = 0; i < 7; i++) drain_ts[i] = 32'(i + 1);
    drain_ts[7] = 32'd10;
    drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d.valid", i), 64'(evt_valid), 64'd1);
      chk($sformatf("drain%0d.ts", i), 64'(evt_ts), 64'(drain_ts[i]));
      chk($sformatf("drain%0d.fire", i), 64'(evt_fire), 64'h3);
      step();
    end
    chk("drained.valid", 64'(evt_valid), 64'd0);
    chk("drained.status", 64'(status), 64'b11);

    // Drop counter saturation: 8 stored, 292 dropped.
    drive(1'b1, 1'b0, 4'h1, 1'b0, 4'h0);
    for (int i = 0; i < 300; i++) step();
    chk("sat.drop", 64'(drop_cnt), 64'd255);
    chk("sat.status", 64'(status), 64'b11);
    chk("sat.valid", 64'(evt_valid), 64'd1);

    // Asynchronous reset mid-stream, away from the clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk_all("midreset", zero);
    #2;
    reset = 1'b1;
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    for (int i = 0; i < 3; i++) step();
    chk("postreset.valid", 64'(evt_valid), 64'd0);
    chk("postreset.drop", 64'(drop_cnt), 64'd0);

    // First event after reset carries ts 3.
    drive(1'b1, 1'b0, 4'h2, 1'b0, 4'h1);
    step();
    chk_all("postreset.evt", '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0,
                               1'b1, 4'h2, 32'd3, 2'b01, 32'd3, 8'd0, 16'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
